// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encodings and
// bit positions of the internal pipeline write-enable vector.
package hazard_ctrl_pkg;

   localparam int unsigned ST_W = 2;

   localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
   localparam logic [ST_W-1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [ST_W-1:0] ST_FLUSH    = 2'd2;

   localparam int unsigned EN_PC    = 0;
   localparam int unsigned EN_IFID  = 1;
   localparam int unsigned EN_IDEX  = 2;
   localparam int unsigned EN_EXMEM = 3;
   localparam int unsigned EN_W     = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencer: load-use bubbles, branch/jump flushes and
// data-memory freezes, with a sticky wait timeout and stall/flush counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MAX_WAIT     = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_Rt_i,
   input  logic [4:0]       IFID_Rs_i,
   input  logic [4:0]       IFID_Rt_i,
   input  logic             IFID_UsesRt_i,
   input  logic             BranchTaken_i,
   input  logic             Jump_i,
   input  logic             dmem_busy_i,
   input  logic             clr_i,
   output logic             PC_Write_o,
   output logic             IFID_Write_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Bubble_o,
   output logic             IDEX_Write_o,
   output logic             EXMEM_Write_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int unsigned FL_W   = 2;
   localparam int unsigned WAIT_W = 8;

   logic [ST_W-1:0]   state_q, state_d;
   logic [FL_W-1:0]   flush_left_q, flush_left_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic [EN_W-1:0]   wr_en;
   logic              flush, bubble;
   logic              load_use, pending, redirect;

   assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                     ((IDEX_Rt_i == IFID_Rs_i) || (IFID_UsesRt_i && (IDEX_Rt_i == IFID_Rt_i)));

   // A flush still owed survives a freeze in flush_left; ID holds a nop meanwhile.
   assign pending  = (state_q != ST_RUN) && (flush_left_q != '0);
   assign redirect = (BranchTaken_i || Jump_i) && (state_q != ST_FLUSH) && !pending;

   always_comb begin
      state_d      = ST_RUN;
      flush_left_d = flush_left_q;
      wait_cnt_d   = '0;
      timeout_d    = timeout_q;
      wr_en        = '1;
      flush        = 1'b0;
      bubble       = 1'b0;

      if (dmem_busy_i) begin
         wr_en      = '0;
         state_d    = ST_MEM_WAIT;
         wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      end else if (load_use) begin
         wr_en[EN_PC]   = 1'b0;
         wr_en[EN_IFID] = 1'b0;
         bubble         = 1'b1;
      end else if (redirect) begin
         flush        = 1'b1;
         flush_left_d = FL_W'(FLUSH_CYCLES - 1);
      end else if (pending) begin
         flush        = 1'b1;
         flush_left_d = flush_left_q - FL_W'(1);
      end

      if (!dmem_busy_i && (flush_left_d != '0)) begin
         state_d = ST_FLUSH;
      end

      if (clr_i) begin
         timeout_d = 1'b0;
      end else if (dmem_busy_i && (wait_cnt_d == WAIT_W'(MAX_WAIT))) begin
         timeout_d = 1'b1;
      end

      // Reset releases every pipeline register regardless of the request inputs.
      if (rst_i) begin
         wr_en  = '1;
         flush  = 1'b0;
         bubble = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         flush_left_q <= '0;
         wait_cnt_q   <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_left_q <= flush_left_d;
         wait_cnt_q   <= wait_cnt_d;
         timeout_q    <= timeout_d;
      end
   end

   assign PC_Write_o    = wr_en[EN_PC];
   assign IFID_Write_o  = wr_en[EN_IFID];
   assign IDEX_Write_o  = wr_en[EN_IDEX];
   assign EXMEM_Write_o = wr_en[EN_EXMEM];
   assign IFID_Flush_o  = flush;
   assign IDEX_Bubble_o = bubble;
   assign timeout_o     = timeout_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (~wr_en[EN_PC]),
      .clr_i (clr_i),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush),
      .clr_i (clr_i),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_CYCLES=2, MAX_WAIT=16.
module tb_hazard_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        IDEX_MemRead_i = 1'b0;
   logic [4:0]  IDEX_Rt_i = 5'd0;
   logic [4:0]  IFID_Rs_i = 5'd0;
   logic [4:0]  IFID_Rt_i = 5'd0;
   logic        IFID_UsesRt_i = 1'b0;
   logic        BranchTaken_i = 1'b0;
   logic        Jump_i = 1'b0;
   logic        dmem_busy_i = 1'b0;
   logic        clr_i = 1'b0;
   logic        PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o;
   logic        IDEX_Write_o, EXMEM_Write_o, timeout_o;
   logic [15:0] stall_cnt_o, flush_cnt_o;
   logic [5:0]  outs;

   int n_checks = 0;
   int n_errors = 0;

   // {PC, IFID_Write, IFID_Flush, IDEX_Bubble, IDEX_Write, EXMEM_Write}
   localparam logic [5:0] O_RUN   = 6'b110011;
   localparam logic [5:0] O_STALL = 6'b000111;
   localparam logic [5:0] O_FLUSH = 6'b111011;
   localparam logic [5:0] O_FRZ   = 6'b000000;

   hazard_ctrl #(.FLUSH_CYCLES(2), .MAX_WAIT(16), .CNT_W(16)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .IDEX_MemRead_i (IDEX_MemRead_i),
      .IDEX_Rt_i      (IDEX_Rt_i),
      .IFID_Rs_i      (IFID_Rs_i),
      .IFID_Rt_i      (IFID_Rt_i),
      .IFID_UsesRt_i  (IFID_UsesRt_i),
      .BranchTaken_i  (BranchTaken_i),
      .Jump_i         (Jump_i),
      .dmem_busy_i    (dmem_busy_i),
      .clr_i          (clr_i),
      .PC_Write_o     (PC_Write_o),
      .IFID_Write_o   (IFID_Write_o),
      .IFID_Flush_o   (IFID_Flush_o),
      .IDEX_Bubble_o  (IDEX_Bubble_o),
      .IDEX_Write_o   (IDEX_Write_o),
      .EXMEM_Write_o  (EXMEM_Write_o),
      .timeout_o      (timeout_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   assign outs = {PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, IDEX_Write_o, EXMEM_Write_o};

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      IDEX_MemRead_i = 1'b0;
      IDEX_Rt_i      = 5'd0;
      IFID_Rs_i      = 5'd0;
      IFID_Rt_i      = 5'd0;
      IFID_UsesRt_i  = 1'b0;
      BranchTaken_i  = 1'b0;
      Jump_i         = 1'b0;
      dmem_busy_i    = 1'b0;
      clr_i          = 1'b0;
   endtask

   task automatic clear_counters();
      idle();
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_i = 1'b1;
      dmem_busy_i = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_RUN) begin
         n_errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RUN);
      end
      n_checks++;
      if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0 || timeout_o !== 1'b0) begin
         n_errors++; $display("FAIL reset_regs got stall=%0d flush=%0d to=%b exp 0 0 0",
                              stall_cnt_o, flush_cnt_o, timeout_o);
      end
      step();
      step();
      idle();
      rst_i = 1'b0;
      #1;
      n_checks++;
      if (outs !== O_RUN) begin
         n_errors++; $display("FAIL reset_release got=%b exp=%b", outs, O_RUN);
      end
   endtask

   task automatic test_load_use();
      clear_counters();
      IDEX_MemRead_i = 1'b1; IDEX_Rt_i = 5'd8; IFID_Rs_i = 5'd8;
      #1;
      n_checks++;
      if (outs !== O_STALL) begin
         n_errors++; $display("FAIL lu_stall got=%b exp=%b", outs, O_STALL);
      end
      step();
      idle();
      #1;
      n_checks++;
      if (outs !== O_RUN) begin
         n_errors++; $display("FAIL lu_one_bubble got=%b exp=%b", outs, O_RUN);
      end
      n_checks++;
      if (stall_cnt_o !== 16'd1) begin
         n_errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt_o);
      end
      IDEX_MemRead_i = 1'b1; IDEX_Rt_i = 5'd0; IFID_Rs_i = 5'd0;
      #1;
      n_checks++;
      if (outs !== O_RUN) begin
         n_errors++; $display("FAIL lu_rt_zero got=%b exp=%b", outs, O_RUN);
      end
      step();
      IDEX_Rt_i = 5'd5; IFID_Rt_i = 5'd5; IFID_Rs_i = 5'd3; IFID_UsesRt_i = 1'b0;
      #1;
      n_checks++;
      if (outs !== O_RUN) begin
         n_errors++; $display("FAIL lu_rt_unused got=%b exp=%b", outs, O_RUN);
      end
      IFID_UsesRt_i = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_STALL) begin
         n_errors++; $display("FAIL lu_rt_used got=%b exp=%b", outs, O_STALL);
      end
      step();
      idle();
      #1;
      n_checks++;
      if (stall_cnt_o !== 16'd2) begin
         n_errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", stall_cnt_o);
      end
   endtask

   task automatic test_flush();
      clear_counters();
      BranchTaken_i = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_FLUSH) begin
         n_errors++; $display("FAIL fl_first got=%b exp=%b", outs, O_FLUSH);
      end
      step();
      #1;
      n_checks++;
      if (outs !== O_FLUSH) begin
         n_errors++; $display("FAIL fl_second got=%b exp=%b", outs, O_FLUSH);
      end
      step();
      BranchTaken_i = 1'b0;
      #1;
      n_checks++;
      if (outs !== O_RUN) begin
         n_errors++; $display("FAIL fl_done got=%b exp=%b", outs, O_RUN);
      end
      n_checks++;
      if (flush_cnt_o !== 16'd2) begin
         n_errors++; $display("FAIL fl_cnt got=%0d exp=2", flush_cnt_o);
      end
      BranchTaken_i = 1'b1;
      #1;
      step();
      BranchTaken_i = 1'b0; dmem_busy_i = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_FRZ) begin
         n_errors++; $display("FAIL fl_freeze got=%b exp=%b", outs, O_FRZ);
      end
      step();
      dmem_busy_i = 1'b0;
      #1;
      n_checks++;
      if (outs !== O_FLUSH) begin
         n_errors++; $display("FAIL fl_resume got=%b exp=%b", outs, O_FLUSH);
      end
      step();
      #1;
      n_checks++;
      if (outs !== O_RUN) begin
         n_errors++; $display("FAIL fl_resume_done got=%b exp=%b", outs, O_RUN);
      end
      n_checks++;
      if (flush_cnt_o !== 16'd4 || stall_cnt_o !== 16'd1) begin
         n_errors++; $display("FAIL fl_cnts got flush=%0d stall=%0d exp 4 1", flush_cnt_o, stall_cnt_o);
      end
   endtask

   task automatic test_timeout();
      clear_counters();
      dmem_busy_i = 1'b1;
      repeat (15) step();
      n_checks++;
      if (timeout_o !== 1'b0) begin
         n_errors++; $display("FAIL to_15 got=%b exp=0", timeout_o);
      end
      dmem_busy_i = 1'b0;
      step();
      dmem_busy_i = 1'b1;
      repeat (15) step();
      n_checks++;
      if (timeout_o !== 1'b0) begin
         n_errors++; $display("FAIL to_restart got=%b exp=0", timeout_o);
      end
      step();
      n_checks++;
      if (timeout_o !== 1'b1) begin
         n_errors++; $display("FAIL to_16 got=%b exp=1", timeout_o);
      end
      dmem_busy_i = 1'b0;
      step();
      n_checks++;
      if (timeout_o !== 1'b1 || stall_cnt_o !== 16'd31) begin
         n_errors++; $display("FAIL to_sticky got to=%b stall=%0d exp 1 31", timeout_o, stall_cnt_o);
      end
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      n_checks++;
      if (timeout_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
         n_errors++; $display("FAIL to_clr got to=%b stall=%0d exp 0 0", timeout_o, stall_cnt_o);
      end
   endtask

   task automatic test_priority();
      clear_counters();
      IDEX_MemRead_i = 1'b1; IDEX_Rt_i = 5'd8; IFID_Rs_i = 5'd8; Jump_i = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_STALL) begin
         n_errors++; $display("FAIL pr_lu_jump got=%b exp=%b", outs, O_STALL);
      end
      step();
      IDEX_MemRead_i = 1'b0;
      #1;
      n_checks++;
      if (outs !== O_FLUSH) begin
         n_errors++; $display("FAIL pr_jump_next got=%b exp=%b", outs, O_FLUSH);
      end
      step();
      Jump_i = 1'b0;
      #1;
      n_checks++;
      if (outs !== O_FLUSH) begin
         n_errors++; $display("FAIL pr_jump_flush2 got=%b exp=%b", outs, O_FLUSH);
      end
      step();
      #1;
      n_checks++;
      if (outs !== O_RUN || stall_cnt_o !== 16'd1 || flush_cnt_o !== 16'd2) begin
         n_errors++; $display("FAIL pr_jump_done got=%b stall=%0d flush=%0d exp %b 1 2",
                              outs, stall_cnt_o, flush_cnt_o, O_RUN);
      end
      dmem_busy_i = 1'b1; IDEX_MemRead_i = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_FRZ) begin
         n_errors++; $display("FAIL pr_busy_lu got=%b exp=%b", outs, O_FRZ);
      end
      step();
      idle();
      #1;
      n_checks++;
      if (outs !== O_RUN || stall_cnt_o !== 16'd2) begin
         n_errors++; $display("FAIL pr_busy_after got=%b stall=%0d exp %b 2", outs, stall_cnt_o, O_RUN);
      end
   endtask

   task automatic test_reset_in_flush();
      BranchTaken_i = 1'b1;
      #1;
      step();
      BranchTaken_i = 1'b0;
      rst_i = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_RUN || stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
         n_errors++; $display("FAIL rf_async got=%b stall=%0d flush=%0d exp %b 0 0",
                              outs, stall_cnt_o, flush_cnt_o, O_RUN);
      end
      step();
      rst_i = 1'b0;
      #1;
      n_checks++;
      if (outs !== O_RUN) begin
         n_errors++; $display("FAIL rf_no_pending got=%b exp=%b", outs, O_RUN);
      end
      step();
      n_checks++;
      if (flush_cnt_o !== 16'd0) begin
         n_errors++; $display("FAIL rf_flush_cnt got=%0d exp=0", flush_cnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_flush();
      test_timeout();
      test_priority();
      test_reset_in_flush();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
